// File: rtl/mod_arith_pkg.sv
// Shared constants and types for the modular-arithmetic datapath.
package mod_arith_pkg;

  localparam int unsigned  DefWidth  = 32;
  localparam logic [31:0]  DefMod    = 32'd998244353;
  // -MOD^-1 mod 2^32
  localparam logic [31:0]  DefNprime = 32'd998244351;
  // 2^64 mod MOD, used to leave the Montgomery domain in one extra reduction
  localparam logic [31:0]  DefR2mod  = 32'd932051910;
  localparam int unsigned  DefIdxW   = $clog2(DefWidth);

  typedef enum logic [1:0] {
    StIdle,
    StSqr,
    StMul
  } state_e;

endpackage

// File: rtl/mod_mul.sv
// Combinational modular multiplier: p = a * b mod MOD.
// Two Montgomery reductions: redc(a*b) = a*b*R^-1, then redc(that * R^2) = a*b.
// Requires a*b < MOD * 2^WIDTH, which holds when at least one operand is already reduced.
module mod_mul
  import mod_arith_pkg::*;
#(
  parameter int unsigned      WIDTH  = DefWidth,
  parameter logic [WIDTH-1:0] MOD    = DefMod,
  parameter logic [WIDTH-1:0] NPRIME = DefNprime,
  parameter logic [WIDTH-1:0] R2MOD  = DefR2mod
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] p_o
);

  localparam int unsigned PW = 2 * WIDTH;

  // Montgomery reduction: returns t * 2^-WIDTH mod MOD for t < MOD * 2^WIDTH.
  function automatic logic [WIDTH-1:0] redc(input logic [PW-1:0] t);
    logic [WIDTH-1:0] m;
    logic [PW:0]      s;
    logic [WIDTH:0]   u;
    m = t[WIDTH-1:0] * NPRIME;
    s = {1'b0, t} + ((PW+1)'(m) * (PW+1)'(MOD));
    u = s[PW:WIDTH];
    if (u >= (WIDTH+1)'(MOD)) begin
      u = u - (WIDTH+1)'(MOD);
    end
    return u[WIDTH-1:0];
  endfunction

  logic [PW-1:0]    prod_ab;
  logic [WIDTH-1:0] mont_ab;
  logic [PW-1:0]    prod_r2;

  // Product, reduce into Montgomery form, then scale back by R^2.
  always_comb begin
    prod_ab = PW'(a_i) * PW'(b_i);
    mont_ab = redc(prod_ab);
    prod_r2 = PW'(mont_ab) * PW'(R2MOD);
    p_o     = redc(prod_r2);
  end

endmodule

// File: rtl/mod_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer: result = base^exp mod MOD.
// One mod_mul evaluation per clock, registered into acc.
// Build option MOD_EXP_LEADZERO_SKIP_EN: start the bit index at the MSB of exp
// instead of WIDTH-1, skipping squarings of acc=1. Results are identical either way.
module mod_exp_ctrl
  import mod_arith_pkg::*;
#(
  parameter int unsigned      WIDTH  = DefWidth,
  parameter logic [WIDTH-1:0] MOD    = DefMod,
  parameter logic [WIDTH-1:0] NPRIME = DefNprime,
  parameter logic [WIDTH-1:0] R2MOD  = DefR2mod
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [WIDTH-1:0] base_i,
  input  logic [WIDTH-1:0] exp_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  localparam int unsigned IdxW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] base_q, base_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             done_q, done_d;

  logic [IdxW-1:0]  start_idx;
  logic [WIDTH-1:0] mul_b;
  logic [WIDTH-1:0] mul_p;

  mod_mul #(
    .WIDTH  (WIDTH),
    .MOD    (MOD),
    .NPRIME (NPRIME),
    .R2MOD  (R2MOD)
  ) u_mul (
    .a_i (acc_q),
    .b_i (mul_b),
    .p_o (mul_p)
  );

`ifdef MOD_EXP_LEADZERO_SKIP_EN
  // Priority encoder: index of the highest set bit of exp; exp==0 maps to 0 (one no-op square).
  always_comb begin
    start_idx = '0;
    for (int unsigned k = 0; k < WIDTH; k++) begin
      if (exp_i[k]) start_idx = IdxW'(k);
    end
  end
`else
  // Always walk the full exponent width.
  assign start_idx = IdxW'(WIDTH - 1);
`endif

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      acc_q    <= '0;
      base_q   <= '0;
      exp_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      base_q   <= base_d;
      exp_q    <= exp_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  // Next-state: walk exponent bits MSB first, one square (and optional multiply) per bit.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    base_d   = base_q;
    exp_d    = exp_q;
    result_d = result_q;
    done_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          base_d  = base_i;
          exp_d   = exp_i;
          acc_d   = WIDTH'(1);
          idx_d   = start_idx;
          state_d = StSqr;
        end
      end
      StSqr: begin
        acc_d = mul_p;
        if (exp_q[idx_q]) begin
          state_d = StMul;
        end else if (idx_q == '0) begin
          result_d = mul_p;
          done_d   = 1'b1;
          state_d  = StIdle;
        end else begin
          idx_d = idx_q - IdxW'(1);
        end
      end
      StMul: begin
        acc_d = mul_p;
        if (idx_q == '0) begin
          result_d = mul_p;
          done_d   = 1'b1;
          state_d  = StIdle;
        end else begin
          idx_d   = idx_q - IdxW'(1);
          state_d = StSqr;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs and multiplier operand select.
  always_comb begin
    mul_b    = (state_q == StMul) ? base_q : acc_q;
    busy_o   = (state_q != StIdle);
    done_o   = done_q;
    result_o = result_q;
  end

endmodule

// File: tb/tb_mod_exp_ctrl.sv
// Directed bench for mod_exp_ctrl; expected latencies follow the build option
// MOD_EXP_LEADZERO_SKIP_EN when it is defined.
module tb_mod_exp_ctrl;

  localparam logic [31:0] P = 32'd998244353;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] base = '0;
  logic [31:0] exp = '0;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_checks = 0;
  int n_fail = 0;

  mod_exp_ctrl u_dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .start_i  (start),
    .base_i   (base),
    .exp_i    (exp),
    .busy_o   (busy),
    .done_o   (done),
    .result_o (result)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  function automatic int exp_lat(input logic [31:0] e);
`ifdef MOD_EXP_LEADZERO_SKIP_EN
    int m = 0;
    for (int k = 0; k < 32; k++) if (e[k]) m = k;
    return m + 1 + $countones(e);
`else
    return 32 + $countones(e);
`endif
  endfunction

  // Called on the negedge after the accepting edge; returns at the negedge where busy is low.
  task automatic wait_finish(output int cycles);
    cycles = 0;
    while (busy === 1'b1 && cycles < 300) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  task automatic launch(input logic [31:0] b, input logic [31:0] e);
    start = 1'b1;
    base  = b;
    exp   = e;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_check(input string tag, input logic [31:0] b, input logic [31:0] e,
                           input logic [31:0] want);
    int c;
    launch(b, e);
    wait_finish(c);
    check_eq({tag, " latency"}, c, exp_lat(e));
    check_eq({tag, " done"}, {31'b0, done}, 32'd1);
    check_eq({tag, " result"}, result, want);
    @(negedge clk);
    check_eq({tag, " done drop"}, {31'b0, done}, 32'd0);
    check_eq({tag, " result held"}, result, want);
  endtask

  initial begin
    int c;
    int saw_done;
    #2_000_000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int c;
    int saw_done;
    repeat (2) @(negedge clk);
    check_eq("reset busy", {31'b0, busy}, 32'd0);
    check_eq("reset done", {31'b0, done}, 32'd0);
    check_eq("reset result", result, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_check("3^0", 32'd3, 32'd0, 32'd1);
    run_check("2^10", 32'd2, 32'd10, 32'd1024);
    run_check("(P-1)^2", P - 32'd1, 32'd2, 32'd1);
    // 4294967295 - 4*998244353 = 301989883
    run_check("ffffffff^1", 32'hFFFF_FFFF, 32'd1, 32'd301989883);
    run_check("3^(P-2)", 32'd3, P - 32'd2, 32'd332748118);
    run_check("5^(P-1)", 32'd5, P - 32'd1, 32'd1);

    // Start held for three cycles; operands change after acceptance and must be ignored.
    start = 1'b1;
    base  = 32'd7;
    exp   = 32'd5;
    c = 0;
    saw_done = 0;
    for (int i = 0; i < 300 && saw_done == 0; i++) begin
      @(negedge clk);
      if (i == 0) begin
        base = 32'd9;
        exp  = 32'd3;
      end
      if (i == 2) start = 1'b0;
      if (busy) c++;
      if (done) saw_done = 1;
    end
    check_eq("7^5 done seen", saw_done, 1);
    check_eq("7^5 latency", c, exp_lat(32'd5));
    check_eq("7^5 result", result, 32'd16807);
    // Restart in the done cycle.
    launch(32'd2, 32'd10);
    check_eq("restart busy", {31'b0, busy}, 32'd1);
    check_eq("restart done drop", {31'b0, done}, 32'd0);
    check_eq("restart result held", result, 32'd16807);
    wait_finish(c);
    check_eq("restart latency", c, exp_lat(32'd10));
    check_eq("restart result", result, 32'd1024);
    @(negedge clk);

    // Asynchronous abort mid-run.
    launch(32'd3, P - 32'd2);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("abort busy", {31'b0, busy}, 32'd0);
    check_eq("abort done", {31'b0, done}, 32'd0);
    check_eq("abort result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 0;
    repeat (4) begin
      @(negedge clk);
      if (done || busy) saw_done = 1;
    end
    check_eq("abort idle after", saw_done, 0);
    run_check("post-abort 2^10", 32'd2, 32'd10, 32'd1024);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
